// File: rtl/xmem_port_arb.sv
// xmem_port_arb: shares one Versat xmem external access port among N_REQ
// host requesters, returns read data to the issuing requester, and sequences
// engine runs so external accesses and address-generator runs never overlap.
//
// Build option: define XMEM_ARB_PRIO_EN to give requester 0 fixed top
// priority, with the remaining requesters rotating round-robin among
// themselves. When it is undefined, all requesters rotate round-robin.
module xmem_port_arb #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int READ_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    input  logic                      run_req,
    output logic                      run_ack,
    output logic                      busy,
    output logic                      mem_valid,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      mem_run,
    input  logic                      mem_done
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            done_seen;
    logic            done_seen_nxt;
    logic            run_ack_nxt;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;
    logic            grant_open;
    logic            accept;
    logic            tags_pending;

    // Stage k holds a read tag k+1 cycles after its acceptance; the last
    // stage lines up with the memory's read data.
    logic [READ_LAT:0] tag_vld;
    logic [ID_W-1:0]   tag_id [READ_LAT+1];

    // Pick the candidate requester: search starts just after the last grant.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
`ifdef XMEM_ARB_PRIO_EN
        if (req_valid[0]) begin
            gnt_any = 1'b1;
            gnt_id  = '0;
        end else begin
            for (int off = 1; off <= N_REQ; off++) begin
                idx = (int'(rr_ptr) + off) % N_REQ;
                if (!gnt_any && idx != 0 && req_valid[idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = ID_W'(idx);
                end
            end
        end
`else
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
`endif
    end

    // Grants are only offered in IDLE when no run is being requested.
    always_comb begin
        grant_open = (state == S_IDLE) && !run_req;
        req_ready  = '0;
        if (grant_open && gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
        accept = |req_ready;
    end

    // Round-robin pointer remembers the last accepted requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= ID_W'(N_REQ - 1);
        end else if (accept) begin
`ifdef XMEM_ARB_PRIO_EN
            if (gnt_id != '0) begin
                rr_ptr <= gnt_id;
            end
`else
            rr_ptr <= gnt_id;
`endif
        end
    end

    // Register the accepted access toward xmem for exactly one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_valid <= 1'b1;
            mem_we    <= req_we[gnt_id];
            mem_addr  <= req_addr[gnt_id*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[gnt_id*DATA_W +: DATA_W];
        end else begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end
    end

    // Shift read tags along so each one exits when its data arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= READ_LAT; k++) begin
                tag_vld[k] <= 1'b0;
                tag_id[k]  <= '0;
            end
        end else begin
            tag_vld[0] <= accept && !req_we[gnt_id];
            tag_id[0]  <= gnt_id;
            for (int k = 1; k <= READ_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Route the exiting tag to its requester with the live memory data.
    always_comb begin
        rsp_valid = '0;
        if (tag_vld[READ_LAT]) begin
            rsp_valid[tag_id[READ_LAT]] = 1'b1;
        end
        rsp_rdata = (|rsp_valid) ? mem_rdata : '0;
    end

    // A tag in the second-to-last stage exits during LAUNCH, so only the
    // earlier stages hold back the run.
    always_comb begin
        tags_pending = 1'b0;
        for (int k = 0; k <= READ_LAT - 2; k++) begin
            tags_pending = tags_pending | tag_vld[k];
        end
    end

    // Run sequencer state register and zero-length-run detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            done_seen <= 1'b0;
            run_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_seen <= done_seen_nxt;
            run_ack   <= run_ack_nxt;
        end
    end

    // Run sequencer next-state logic.
    always_comb begin
        state_nxt     = state;
        done_seen_nxt = 1'b0;
        run_ack_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tags_pending) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!mem_done) begin
                    state_nxt = S_WAIT_HIGH;
                end else if (done_seen) begin
                    state_nxt   = S_IDLE;
                    run_ack_nxt = 1'b1;
                end else begin
                    done_seen_nxt = 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (mem_done) begin
                    state_nxt   = S_IDLE;
                    run_ack_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign mem_run = (state == S_LAUNCH);

endmodule

// File: tb/tb_xmem_port_arb.sv
// tb_xmem_port_arb: directed bench for xmem_port_arb with a small xmem
// stand-in (3-cycle read latency). Expected grants follow the build option
// XMEM_ARB_PRIO_EN when it is defined.
module tb_xmem_port_arb;

    localparam int N_REQ    = 2;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 11;
    localparam int READ_LAT = 3;

`ifdef XMEM_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    run_req;
    logic                    run_ack;
    logic                    busy;
    logic                    mem_valid;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_run;
    logic                    mem_done;

    logic [DATA_W-1:0] mem [0:2047];
    logic [DATA_W-1:0] rd0, rd1, rd2;

    int checks   = 0;
    int failures = 0;

    xmem_port_arb #(
        .N_REQ    (N_REQ),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .run_req   (run_req),
        .run_ack   (run_ack),
        .busy      (busy),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_run   (mem_run),
        .mem_done  (mem_done)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: preloaded while reset is held, read data 3 cycles
    // after the access cycle.
    always @(posedge clk) begin
        if (!rst) begin
            mem[5] <= 32'hDEAD_BEEF;
            mem[9] <= 32'h1234_5678;
        end else if (mem_valid && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd0 <= mem[mem_addr];
        rd1 <= rd0;
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic [10:0] a0, input logic [10:0] a1,
                                 input logic [31:0] w0, input logic [31:0] w1);
        req_valid = valid;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {w1, w0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        run_req   = 1'b0;
        mem_done  = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset values");
        checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("rst_mem_valid", 64'(mem_valid), 64'h0);
        checkOutput("rst_mem_we",    64'(mem_we),    64'h0);
        checkOutput("rst_mem_run",   64'(mem_run),   64'h0);
        checkOutput("rst_run_ack",   64'(run_ack),   64'h0);
        checkOutput("rst_busy",      64'(busy),      64'h0);
        checkOutput("rst_mem_addr",  64'(mem_addr),  64'h0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        rst = 1'b1;
        tick();
        tick();

        // Single read: requester 1, address 0x005.
        $display("[TB] single read");
        applyStimulus(2'b10, 2'b00, 11'h000, 11'h005, 32'h0, 32'h0);
        checkOutput("rd_ready", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0);
        checkOutput("rd_mem_valid", 64'(mem_valid), 64'h1);
        checkOutput("rd_mem_addr",  64'(mem_addr),  64'h5);
        checkOutput("rd_mem_we",    64'(mem_we),    64'h0);
        checkOutput("rd_rsp_early", 64'(rsp_valid), 64'h0);
        tick();
        tick();
        checkOutput("rd_rsp_t3", 64'(rsp_valid), 64'h0);
        tick();
        checkOutput("rd_rsp_valid", 64'(rsp_valid), 64'h2);
        checkOutput("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        tick();
        checkOutput("rd_rsp_after", 64'(rsp_valid), 64'h0);

        // Contention: both requesters write for 4 cycles.
        $display("[TB] contention");
        applyStimulus(2'b11, 2'b11, 11'h010, 11'h020, 32'hA0A0_A0A0, 32'hB1B1_B1B1);
        checkOutput("ct_gnt0", 64'(req_ready), 64'h1);
        tick();
        checkOutput("ct_gnt1", 64'(req_ready), 64'(PRIO ? 2'b01 : 2'b10));
        checkOutput("ct_addr0", 64'(mem_addr), 64'h10);
        checkOutput("ct_wdata0", 64'(mem_wdata), 64'hA0A0_A0A0);
        checkOutput("ct_we0", 64'(mem_we), 64'h1);
        tick();
        checkOutput("ct_gnt2", 64'(req_ready), 64'h1);
        checkOutput("ct_addr1", 64'(mem_addr), 64'(PRIO ? 11'h010 : 11'h020));
        tick();
        checkOutput("ct_gnt3", 64'(req_ready), 64'(PRIO ? 2'b01 : 2'b10));
        checkOutput("ct_addr2", 64'(mem_addr), 64'h10);
        tick();
        applyStimulus(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0);
        checkOutput("ct_valid3", 64'(mem_valid), 64'h1);
        checkOutput("ct_addr3", 64'(mem_addr), 64'(PRIO ? 11'h010 : 11'h020));
        tick();
        checkOutput("ct_idle", 64'(mem_valid), 64'h0);

        // Run interlock after a read, then a 20-cycle engine run.
        $display("[TB] run interlock");
        applyStimulus(2'b01, 2'b00, 11'h009, 11'h005, 32'h0, 32'h0);
        checkOutput("il_rd_ready", 64'(req_ready), 64'h1);
        tick();
        run_req = 1'b1;
        applyStimulus(2'b11, 2'b11, 11'h009, 11'h005, 32'hC0C0_C0C0, 32'hC1C1_C1C1);
        checkOutput("il_no_gnt_t1", 64'(req_ready), 64'h0);
        checkOutput("il_busy_t1", 64'(busy), 64'h0);
        checkOutput("il_mem_valid_t1", 64'(mem_valid), 64'h1);
        tick();
        checkOutput("il_busy_t2", 64'(busy), 64'h1);
        checkOutput("il_no_gnt_t2", 64'(req_ready), 64'h0);
        checkOutput("il_run_t2", 64'(mem_run), 64'h0);
        tick();
        checkOutput("il_run_t3", 64'(mem_run), 64'h0);
        tick();
        run_req = 1'b0;
        checkOutput("il_run_t4", 64'(mem_run), 64'h1);
        checkOutput("il_rsp_t4", 64'(rsp_valid), 64'h1);
        checkOutput("il_rdata_t4", 64'(rsp_rdata), 64'h1234_5678);
        tick();
        mem_done = 1'b0;
        checkOutput("il_run_t5", 64'(mem_run), 64'h0);
        checkOutput("il_busy_t5", 64'(busy), 64'h1);
        repeat (19) tick();
        checkOutput("il_no_gnt_t24", 64'(req_ready), 64'h0);
        checkOutput("il_ack_t24", 64'(run_ack), 64'h0);
        tick();
        mem_done = 1'b1;
        #1;
        checkOutput("il_ack_t25", 64'(run_ack), 64'h0);
        checkOutput("il_busy_t25", 64'(busy), 64'h1);
        tick();
        checkOutput("il_ack_t26", 64'(run_ack), 64'h1);
        checkOutput("il_busy_t26", 64'(busy), 64'h0);
        checkOutput("il_gnt_t26", 64'(req_ready), 64'(PRIO ? 2'b01 : 2'b10));
        tick();
        applyStimulus(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0);
        checkOutput("il_ack_t27", 64'(run_ack), 64'h0);
        checkOutput("il_wr_we", 64'(mem_we), 64'h1);
        checkOutput("il_wr_addr", 64'(mem_addr), 64'(PRIO ? 11'h009 : 11'h005));

        // Zero-length run with run_req held, then a short run.
        $display("[TB] zero-length run");
        tick();
        run_req = 1'b1;
        #1;
        checkOutput("zl_busy_z0", 64'(busy), 64'h0);
        tick();
        checkOutput("zl_busy_z1", 64'(busy), 64'h1);
        checkOutput("zl_run_z1", 64'(mem_run), 64'h0);
        tick();
        checkOutput("zl_run_z2", 64'(mem_run), 64'h1);
        tick();
        checkOutput("zl_run_z3", 64'(mem_run), 64'h0);
        checkOutput("zl_ack_z3", 64'(run_ack), 64'h0);
        tick();
        checkOutput("zl_ack_z4", 64'(run_ack), 64'h0);
        checkOutput("zl_busy_z4", 64'(busy), 64'h1);
        tick();
        checkOutput("zl_ack_z5", 64'(run_ack), 64'h1);
        checkOutput("zl_busy_z5", 64'(busy), 64'h0);
        tick();
        checkOutput("zl_rerun_busy", 64'(busy), 64'h1);
        checkOutput("zl_rerun_ack", 64'(run_ack), 64'h0);
        tick();
        run_req = 1'b0;
        checkOutput("zl_rerun_run", 64'(mem_run), 64'h1);
        tick();
        mem_done = 1'b0;
        checkOutput("sr_busy_z8", 64'(busy), 64'h1);
        tick();
        mem_done = 1'b1;
        #1;
        checkOutput("sr_ack_z9", 64'(run_ack), 64'h0);
        tick();
        checkOutput("sr_ack_z10", 64'(run_ack), 64'h1);
        checkOutput("sr_busy_z10", 64'(busy), 64'h0);

        // Reset with two reads in flight.
        $display("[TB] reset with reads in flight");
        tick();
        applyStimulus(2'b10, 2'b00, 11'h005, 11'h009, 32'h0, 32'h0);
        checkOutput("rr_gnt1", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(2'b01, 2'b00, 11'h005, 11'h009, 32'h0, 32'h0);
        checkOutput("rr_gnt0", 64'(req_ready), 64'h1);
        tick();
        applyStimulus(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("rr_rsp_in_rst", 64'(rsp_valid), 64'h0);
        checkOutput("rr_mem_valid_in_rst", 64'(mem_valid), 64'h0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rr_no_rsp", 64'(rsp_valid), 64'h0);
            checkOutput("rr_no_ack", 64'(run_ack), 64'h0);
        end
        applyStimulus(2'b11, 2'b11, 11'h030, 11'h031, 32'h0, 32'h0);
        checkOutput("rr_first_gnt", 64'(req_ready), 64'h1);
        tick();
        applyStimulus(2'b00, 2'b00, 11'h000, 11'h000, 32'h0, 32'h0);
        checkOutput("rr_first_addr", 64'(mem_addr), 64'h30);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
